// File: rtl/pb_pkg.sv
// Shared constants and auto-repeat state type for pb_event_filter.
// Auto-repeat logic elsewhere is built only when PB_AUTO_REPEAT_EN is defined.
package pb_pkg;

  localparam int PB_DEBOUNCE_50MHZ      = 500000;
  localparam int PB_REPEAT_DELAY_50MHZ  = 25000000;
  localparam int PB_REPEAT_PERIOD_50MHZ = 5000000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rpt_state_e;

  // Width of a counter that must reach max(delay, period) - 1.
  function automatic int rpt_cnt_w(input int delay, input int period);
    int longest;
    longest = (delay > period) ? delay : period;
    return (longest > 1) ? $clog2(longest) : 1;
  endfunction

endpackage

// File: rtl/pb_channel.sv
// One push-button channel: synchroniser, debounce, press/release pulses and,
// when PB_AUTO_REPEAT_EN is defined, the per-button auto-repeat FSM.
module pb_channel
  import pb_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = PB_DEBOUNCE_50MHZ,
  parameter int REPEAT_DELAY    = PB_REPEAT_DELAY_50MHZ,
  parameter int REPEAT_PERIOD   = PB_REPEAT_PERIOD_50MHZ
) (
  input  logic clk,
  input  logic rst,
  input  logic pb_n,
  input  logic press_allow,
  output logic st,
  output logic press_req,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  logic             sync1_q, sync1_d;
  logic             s_q, s_d;
  logic             st_q, st_d;
  logic             press_pulse_q, press_pulse_d;
  logic             release_pulse_q, release_pulse_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A press about to be accepted this edge; the top uses it for arbitration.
  assign press_req = ~s_q & st_q & (cnt_q == CNT_LAST);

  always_comb begin
    sync1_d         = pb_n;
    s_d             = sync1_q;
    st_d            = st_q;
    cnt_d           = CNT_ZERO;
    press_pulse_d   = 1'b0;
    release_pulse_d = 1'b0;
    if (s_q == st_q) begin
      cnt_d = CNT_ZERO;
    end else if (st_q && !press_allow) begin
      cnt_d = CNT_ZERO;
    end else if (cnt_q == CNT_LAST) begin
      st_d            = s_q;
      press_pulse_d   = ~s_q;
      release_pulse_d = s_q;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q         <= 1'b1;
      s_q             <= 1'b1;
      st_q            <= 1'b1;
      cnt_q           <= CNT_ZERO;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
    end else begin
      sync1_q         <= sync1_d;
      s_q             <= s_d;
      st_q            <= st_d;
      cnt_q           <= cnt_d;
      press_pulse_q   <= press_pulse_d;
      release_pulse_q <= release_pulse_d;
    end
  end

  assign st            = st_q;
  assign press_pulse   = press_pulse_q;
  assign release_pulse = release_pulse_q;

`ifdef PB_AUTO_REPEAT_EN
  localparam int               RPT_W       = rpt_cnt_w(REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);
  localparam logic [RPT_W-1:0] RPT_ONE     = RPT_W'(1);
  localparam logic [RPT_W-1:0] RPT_ZERO    = RPT_W'(0);

  rpt_state_e       rpt_state_q;
  logic [RPT_W-1:0] rpt_cnt_q;
  logic             repeat_pulse_q;

  // An accepted release wins over any pending repeat fire on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rpt_state_q    <= IDLE;
      rpt_cnt_q      <= RPT_ZERO;
      repeat_pulse_q <= 1'b0;
    end else begin
      repeat_pulse_q <= 1'b0;
      if (release_pulse_d) begin
        rpt_state_q <= IDLE;
        rpt_cnt_q   <= RPT_ZERO;
      end else begin
        case (rpt_state_q)
          IDLE: begin
            rpt_cnt_q <= RPT_ZERO;
            if (press_pulse_d) begin
              rpt_state_q <= DELAY;
            end else begin
              rpt_state_q <= IDLE;
            end
          end
          DELAY: begin
            if (rpt_cnt_q == DELAY_LAST) begin
              repeat_pulse_q <= 1'b1;
              rpt_state_q    <= REPEAT;
              rpt_cnt_q      <= RPT_ZERO;
            end else begin
              rpt_cnt_q <= rpt_cnt_q + RPT_ONE;
            end
          end
          REPEAT: begin
            if (rpt_cnt_q == PERIOD_LAST) begin
              repeat_pulse_q <= 1'b1;
              rpt_cnt_q      <= RPT_ZERO;
            end else begin
              rpt_cnt_q <= rpt_cnt_q + RPT_ONE;
            end
          end
          default: begin
            rpt_state_q <= IDLE;
            rpt_cnt_q   <= RPT_ZERO;
          end
        endcase
      end
    end
  end

  assign repeat_pulse = repeat_pulse_q;
`else
  logic unused_rpt_cfg;
  assign unused_rpt_cfg = (REPEAT_DELAY > 0) ^ (REPEAT_PERIOD > 0);
  assign repeat_pulse   = 1'b0;
`endif

endmodule

// File: rtl/pb_event_filter.sv
// Debounced push-button filter with press/release/repeat events and optional
// one-at-a-time lock; auto-repeat is built only with PB_AUTO_REPEAT_EN defined.
module pb_event_filter
  import pb_pkg::*;
#(
  parameter int NUM_PB          = 4,
  parameter int DEBOUNCE_CYCLES = PB_DEBOUNCE_50MHZ,
  parameter int LOCK_EN         = 0,
  parameter int REPEAT_DELAY    = PB_REPEAT_DELAY_50MHZ,
  parameter int REPEAT_PERIOD   = PB_REPEAT_PERIOD_50MHZ
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_PB-1:0] pb_n,
  output logic [NUM_PB-1:0] pb_n_fltrd,
  output logic [NUM_PB-1:0] press_pulse,
  output logic [NUM_PB-1:0] release_pulse,
  output logic [NUM_PB-1:0] repeat_pulse
);

  logic [NUM_PB-1:0] st_s;
  logic [NUM_PB-1:0] press_req_s;
  logic [NUM_PB-1:0] press_allow_s;

  for (genvar i = 0; i < NUM_PB; i++) begin : g_ch
    localparam logic [NUM_PB-1:0] SELF_MASK  = NUM_PB'(1) << i;
    localparam logic [NUM_PB-1:0] OTHER_MASK = ~SELF_MASK;
    localparam logic [NUM_PB-1:0] LOWER_MASK = SELF_MASK - NUM_PB'(1);

    // Blocked while another button is held down or a lower index also wants in.
    assign press_allow_s[i] = (LOCK_EN == 0) |
                              ~(|((~st_s & OTHER_MASK) | (press_req_s & LOWER_MASK)));

    pb_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .pb_n         (pb_n[i]),
      .press_allow  (press_allow_s[i]),
      .st           (st_s[i]),
      .press_req    (press_req_s[i]),
      .press_pulse  (press_pulse[i]),
      .release_pulse(release_pulse[i]),
      .repeat_pulse (repeat_pulse[i])
    );
  end

  assign pb_n_fltrd = st_s;

endmodule
